// File: rtl/bus_mem_responder_pkg.sv
// Shared memory-subsystem definitions: responder state encoding, bus direction
// codes and beat size.
package bus_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } mem_state_e;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/bus_mem_responder_array.sv
// mem_resp_array: word-addressed backing store with asynchronous read and
// synchronous, enabled write. Contents are deliberately not reset.
module mem_resp_array #(
  parameter int DATAW      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATAW-1:0]      wr_data,
  output logic [DATAW-1:0]      rd_data
);

  logic [DATAW-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Burst memory responder: fixed-latency, BEATS-long read/write bursts into an
// internal array. Define MEM_RESP_ADDR_CHECK_EN to flag out-of-range addresses.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int BUSDATAW   = 32,
  parameter int BUSADDRW   = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3,
  parameter int BEATS      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUSADDRW-1:0] mem_addr,
  input  logic                mem_req,
  input  logic                mem_en,
  input  logic                mem_rd_wr,
  input  logic [BUSDATAW-1:0] mem_wr_data,
  output logic                mem_data_valid,
  output logic [BUSDATAW-1:0] mem_data,
  output logic                busy
`ifdef MEM_RESP_ADDR_CHECK_EN
  ,
  output logic                mem_err
`endif
);

  localparam int OFS    = $clog2(BEAT_BYTES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  mem_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic                  dir_q, dir_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  err_q, err_d;

  logic                  xfer;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] beat_idx;
  logic [BUSDATAW-1:0]   arr_rd_data;
  logic                  addr_err;
  logic                  unused_addr_bits;

`ifdef MEM_RESP_ADDR_CHECK_EN
  assign addr_err         = |mem_addr[BUSADDRW-1:DEPTH_LOG2+OFS];
  assign unused_addr_bits = ^mem_addr[OFS-1:0];
`else
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{mem_addr[BUSADDRW-1:DEPTH_LOG2+OFS], mem_addr[OFS-1:0]};
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dir_d   = dir_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_en && mem_req) begin
          base_d  = mem_addr[DEPTH_LOG2+OFS-1:OFS];
          dir_d   = mem_rd_wr;
          err_d   = addr_err;
          beat_d  = '0;
          lat_d   = '0;
          state_d = (LATENCY > 0) ? ST_WAIT : ST_XFER;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAST_WAIT) begin
          state_d = ST_XFER;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_XFER: begin
        // Last beat drops straight back to IDLE so busy falls with it.
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      dir_q   <= BUS_RD;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dir_q   <= dir_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign xfer     = (state_q == ST_XFER);
  assign beat_idx = base_q + DEPTH_LOG2'(beat_q);
  // A beat cut short by reset never reaches the array.
  assign arr_we   = xfer && (dir_q == BUS_WR) && !err_q && !reset;

  mem_resp_array #(
    .DATAW      (BUSDATAW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .addr    (beat_idx),
    .wr_data (mem_wr_data),
    .rd_data (arr_rd_data)
  );

  assign mem_data_valid = xfer;
  assign busy           = (state_q != ST_IDLE);
  assign mem_data       = (xfer && (dir_q == BUS_RD) && !err_q) ? arr_rd_data : '0;

`ifdef MEM_RESP_ADDR_CHECK_EN
  assign mem_err = xfer && err_q;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: directed bursts push expected beats,
// a negedge monitor pops and compares. A LATENCY=0 instance checks timing.
module tb_bus_mem_responder;

  localparam int LAT   = 3;
  localparam int NBEAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_req, mem_en, mem_rd_wr;
  logic [31:0] mem_wr_data;
  logic        dut_valid, dut_busy;
  logic [31:0] dut_data;

  logic [31:0] z_addr;
  logic        z_req, z_en, z_rd_wr;
  logic [31:0] z_wr_data;
  logic        z_valid, z_busy;
  logic [31:0] z_data;

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic dut_err, z_err;
`endif

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic        mon_en       = 1'b0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  bus_mem_responder #(.LATENCY(LAT), .BEATS(NBEAT)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_en         (mem_en),
    .mem_rd_wr      (mem_rd_wr),
    .mem_wr_data    (mem_wr_data),
    .mem_data_valid (dut_valid),
    .mem_data       (dut_data),
    .busy           (dut_busy)
`ifdef MEM_RESP_ADDR_CHECK_EN
    ,
    .mem_err        (dut_err)
`endif
  );

  bus_mem_responder #(.LATENCY(0), .BEATS(NBEAT)) u_dut0 (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (z_addr),
    .mem_req        (z_req),
    .mem_en         (z_en),
    .mem_rd_wr      (z_rd_wr),
    .mem_wr_data    (z_wr_data),
    .mem_data_valid (z_valid),
    .mem_data       (z_data),
    .busy           (z_busy)
`ifdef MEM_RESP_ADDR_CHECK_EN
    ,
    .mem_err        (z_err)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] seq4(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Monitor: every presented beat pops one expectation; idle cycles must show zero data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dut_valid) begin
        if (sb_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_beat: got data 0x%08h, want no beat at %0t", dut_data, $time);
        end else begin
          logic [32:0] exp;
          exp = sb_q.pop_front();
          checkOutput("beat_data", dut_data, exp[31:0]);
`ifdef MEM_RESP_ADDR_CHECK_EN
          checkOutput("beat_err", {31'd0, dut_err}, {31'd0, exp[32]});
`endif
        end
      end else begin
        checkOutput("idle_data_zero", dut_data, 32'd0);
      end
    end
  end

  // Called and returns at a negedge. abort_beat>=0 asserts reset during that beat.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [3:0][31:0] wd, input logic [3:0][31:0] rd_exp,
                               input logic exp_err, input int abort_beat,
                               input logic hold_req, input logic [31:0] addr_during);
    int nexp, cycles, beat;
    nexp = (abort_beat >= 0) ? abort_beat + 1 : NBEAT;
    for (int k = 0; k < nexp; k++) begin
      sb_q.push_back({exp_err, wr ? 32'd0 : rd_exp[k]});
    end
    mem_en = 1'b1; mem_req = 1'b1; mem_addr = addr; mem_rd_wr = wr; mem_wr_data = wd[0];
    @(posedge clk);
    #1;
    checkOutput("busy_on_accept", {31'd0, dut_busy}, 32'd1);
    if (hold_req) mem_addr = addr_during;
    else begin mem_req = 1'b0; mem_en = 1'b0; end
    cycles = 0;
    beat   = 0;
    while (beat < nexp && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (dut_valid) begin
        if (beat == 0) checkOutput("first_beat_latency", cycles, LAT + 1);
        if (wr) mem_wr_data = wd[beat];
        if (beat == abort_beat) reset = 1'b1;
        beat++;
      end else if (beat > 0) begin
        checkOutput("beats_contiguous", {31'd0, dut_valid}, 32'd1);
      end
    end
    if (beat < nexp) checkOutput("burst_timeout_beats", beat, nexp);
    if (abort_beat >= 0) begin
      @(posedge clk);
      #1;
      checkOutput("abort_valid_low", {31'd0, dut_valid}, 32'd0);
      checkOutput("abort_busy_low", {31'd0, dut_busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      @(negedge clk);
      checkOutput("end_valid_low", {31'd0, dut_valid}, 32'd0);
      checkOutput("end_busy_low", {31'd0, dut_busy}, 32'd0);
    end
  endtask

  task automatic zeroLatBurst(input logic [31:0] addr, input logic wr,
                              input logic [3:0][31:0] wd, input logic [3:0][31:0] rd_exp);
    int cycles, beat;
    z_en = 1'b1; z_req = 1'b1; z_addr = addr; z_rd_wr = wr; z_wr_data = wd[0];
    @(posedge clk);
    #1;
    z_req = 1'b0; z_en = 1'b0;
    cycles = 0;
    beat   = 0;
    while (beat < NBEAT && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (z_valid) begin
        if (beat == 0) checkOutput("z_first_beat_latency", cycles, 1);
        if (wr) z_wr_data = wd[beat];
        else checkOutput("z_read_data", z_data, rd_exp[beat]);
        beat++;
      end else begin
        checkOutput("z_beats_contiguous", {31'd0, z_valid}, 32'd1);
      end
    end
    if (beat < NBEAT) checkOutput("z_burst_timeout_beats", beat, NBEAT);
    @(negedge clk);
    checkOutput("z_beat_count_end", {31'd0, z_valid}, 32'd0);
    checkOutput("z_busy_end", {31'd0, z_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mem_addr = '0; mem_req = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_wr_data = '0;
    z_addr = '0; z_req = 1'b0; z_en = 1'b0; z_rd_wr = 1'b0; z_wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {31'd0, dut_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, dut_busy}, 32'd0);
    checkOutput("reset_data", dut_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Write then read back at 0x100.
    applyStimulus(32'h100, 1'b1, seq4(32'hA0), '0, 1'b0, -1, 1'b0, '0);
    applyStimulus(32'h100, 1'b0, '0, seq4(32'hA0), 1'b0, -1, 1'b0, '0);

    // Held request with address moved during WAIT; next burst only after IDLE.
    applyStimulus(32'h200, 1'b1, seq4(32'hD0), '0, 1'b0, -1, 1'b0, '0);
    applyStimulus(32'h100, 1'b0, '0, seq4(32'hA0), 1'b0, -1, 1'b1, 32'h200);
    applyStimulus(32'h200, 1'b0, '0, seq4(32'hD0), 1'b0, -1, 1'b0, '0);

    // Index wrap from the top of the array back to word 0.
    applyStimulus(32'h0, 1'b1, seq4(32'hF0), '0, 1'b0, -1, 1'b0, '0);
    applyStimulus(32'hFF8, 1'b1, seq4(32'hE0), '0, 1'b0, -1, 1'b0, '0);
    applyStimulus(32'hFF8, 1'b0, '0, seq4(32'hE0), 1'b0, -1, 1'b0, '0);
    applyStimulus(32'h0, 1'b0, '0, {32'hF3, 32'hF2, 32'hE3, 32'hE2}, 1'b0, -1, 1'b0, '0);

    // Reset mid-read, then data intact.
    applyStimulus(32'h100, 1'b0, '0, seq4(32'hA0), 1'b0, 1, 1'b0, '0);
    applyStimulus(32'h100, 1'b0, '0, seq4(32'hA0), 1'b0, -1, 1'b0, '0);

    // Reset during the third write beat: only two words replaced.
    applyStimulus(32'h300, 1'b1, seq4(32'hC0), '0, 1'b0, -1, 1'b0, '0);
    applyStimulus(32'h300, 1'b1, seq4(32'hB0), '0, 1'b0, 2, 1'b0, '0);
    applyStimulus(32'h300, 1'b0, '0, {32'hC3, 32'hC2, 32'hB1, 32'hB0}, 1'b0, -1, 1'b0, '0);

`ifdef MEM_RESP_ADDR_CHECK_EN
    applyStimulus(32'h8000_0000, 1'b0, '0, '0, 1'b1, -1, 1'b0, '0);
    applyStimulus(32'h8000_0000, 1'b1, seq4(32'h55), '0, 1'b1, -1, 1'b0, '0);
    applyStimulus(32'h0, 1'b0, '0, {32'hF3, 32'hF2, 32'hE3, 32'hE2}, 1'b0, -1, 1'b0, '0);
`else
    applyStimulus(32'h8000_0100, 1'b0, '0, seq4(32'hA0), 1'b0, -1, 1'b0, '0);
`endif

    // Zero-latency instance: timing plus write/read round trip.
    zeroLatBurst(32'h40, 1'b1, seq4(32'h11), '0);
    zeroLatBurst(32'h40, 1'b0, '0, seq4(32'h11));

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
